// File: rtl/signed_seq_divider.sv
// signed_seq_divider: iterative non-restoring signed divider, one quotient bit
// per clock. Start/done handshake; results held until the next done.
// Optional build macro DIV_BY_ZERO_FAST_EN: a zero divisor skips the
// iterations and completes two edges after acceptance.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module signed_seq_divider #(
  parameter int BIT_WIDTH = `BIT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [BIT_WIDTH-1:0] dividend,
  input  logic signed [BIT_WIDTH-1:0] divisor,
  output logic                        busy,
  output logic                        done,
  output logic signed [BIT_WIDTH-1:0] quotient,
  output logic signed [BIT_WIDTH-1:0] remainder,
  output logic                        overflow,
  output logic                        div_by_zero
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, SIGN} state_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt;
  logic signed [BIT_WIDTH:0]   rem_p;
  logic [BIT_WIDTH-1:0]        quo_p;
  logic [BIT_WIDTH-1:0]        dvs_abs;
  logic signed [BIT_WIDTH-1:0] dvd_raw;
  logic                        dvd_neg, dvs_neg, dvs_zero, ovf_case;
  logic signed [BIT_WIDTH:0]   dvs_ext, rem_sh, rem_step;
  logic                        last_iter;

  // Magnitude as unsigned; |-2^(W-1)| = 2^(W-1) fits in W unsigned bits.
  function automatic logic [BIT_WIDTH-1:0] abs_w(input logic signed [BIT_WIDTH-1:0] x);
    return x[BIT_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // Two's-complement negation, wrapping at -2^(W-1).
  function automatic logic [BIT_WIDTH-1:0] neg_w(input logic [BIT_WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // One non-restoring step: shift {R,Q} left, then add or subtract D by the
  // sign of R. R stays in [-D, D) so its top bit is pure sign extension.
  assign dvs_ext   = $signed({1'b0, dvs_abs});
  assign rem_sh    = {rem_p[BIT_WIDTH-1:0], quo_p[BIT_WIDTH-1]};
  assign rem_step  = rem_p[BIT_WIDTH] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
  assign last_iter = (cnt == CNT_W'(BIT_WIDTH - 1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_BY_ZERO_FAST_EN
          // Zero divisor skips the iterations; FIX is a no-op on R = 0.
          state_nxt = (divisor == '0) ? FIX : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, iteration counter and handshake; busy/done lag the state
  // by one edge so busy rises one edge after acceptance and falls with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state == CALC) || (state == FIX);
      done  <= (state == SIGN);
      if (state == CALC) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  // Result registers: sign correction and special cases, updated only in SIGN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == SIGN) begin
      if (dvs_zero) begin
        quotient    <= '0;
        remainder   <= dvd_raw;
        overflow    <= 1'b0;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= (dvd_neg ^ dvs_neg) ? neg_w(quo_p) : quo_p;
        remainder   <= dvd_neg ? neg_w(rem_p[BIT_WIDTH-1:0]) : rem_p[BIT_WIDTH-1:0];
        overflow    <= ovf_case;
        div_by_zero <= 1'b0;
      end
    end
  end

  // Datapath: operand capture, iteration and final remainder correction.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          dvd_neg  <= dividend[BIT_WIDTH-1];
          dvs_neg  <= divisor[BIT_WIDTH-1];
          dvs_zero <= (divisor == '0);
          ovf_case <= (dividend == {1'b1, {(BIT_WIDTH-1){1'b0}}}) && (divisor == '1);
          dvd_raw  <= dividend;
          dvs_abs  <= abs_w(divisor);
          quo_p    <= abs_w(dividend);
          rem_p    <= '0;
        end
      end
      CALC: begin
        rem_p <= rem_step;
        quo_p <= {quo_p[BIT_WIDTH-2:0], ~rem_step[BIT_WIDTH]};
      end
      FIX: begin
        if (rem_p[BIT_WIDTH]) rem_p <= rem_p + dvs_ext;
      end
      default: ;
    endcase
  end

endmodule
